// File: rtl/hex_msg_scroller.sv
// Character buffer that scrolls its contents right-to-left across NDIG
// 7-segment digits, with blank lead-in and lead-out of NDIG slots each.
module hex_msg_scroller #(
    parameter int DEPTH    = 16,
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [4:0]        wr_char,
    input  logic              clr,
    input  logic              start,
    input  logic              loop,
    output logic [5*NDIG-1:0] char_out,
    output logic [NDIG-1:0]   display,
    output logic              busy,
    output logic              done,
    output logic [4:0]        count,
    output logic              full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for the largest stream index: DEPTH + 2*NDIG - 2.
    localparam int PW = $clog2(DEPTH + 2*NDIG);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] NDIG_P = PW'(NDIG);
    localparam logic [TW-1:0] TLAST  = TW'(TICK_DIV - 1);

    typedef enum logic {IDLE, SCROLL} state_t;

    state_t          state, state_nxt;
    logic [4:0]      count_nxt;
    logic [PW-1:0]   pos, pos_nxt, pend;
    logic [TW-1:0]   tick, tick_nxt;
    logic            done_nxt, wr;
    logic [4:0]      mem [DEPTH];
    logic [5*NDIG-1:0] win_char;
    logic [NDIG-1:0]   win_disp;

    assign full = (count == 5'(DEPTH));
    assign pend = PW'(count) + NDIG_P;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pos_nxt   = pos;
        tick_nxt  = tick;
        done_nxt  = 1'b0;
        wr        = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    count_nxt = '0;
                end else if (start) begin
                    if (count != '0) begin
                        state_nxt = SCROLL;
                        pos_nxt   = '0;
                        tick_nxt  = '0;
                    end
                end else if (wr_en && !full) begin
                    wr        = 1'b1;
                    count_nxt = count + 5'd1;
                end
            end
            SCROLL: begin
                if (clr) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    pos_nxt   = '0;
                    tick_nxt  = '0;
                end else if (tick == TLAST) begin
                    tick_nxt = '0;
                    if (pos + 1'b1 == pend) begin
                        done_nxt = 1'b1;
                        pos_nxt  = '0;
                        if (!loop)
                            state_nxt = IDLE;
                    end else begin
                        pos_nxt = pos + 1'b1;
                    end
                end else begin
                    tick_nxt = tick + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window for the position being loaded this edge; digit NDIG-1 shows stream[pos].
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        win_char = '0;
        win_disp = '1;
        for (int d = 0; d < NDIG; d++) begin
            idx = pos_nxt + PW'(NDIG - 1 - d);
            if (idx >= NDIG_P && idx < pend) begin
                win_char[5*d +: 5] = mem[AW'(idx - NDIG_P)];
                win_disp[d]        = 1'b0;
            end
        end
    end

    // Buffer storage carries no reset; only count decides what is valid.
    always_ff @(posedge clk) begin
        if (wr)
            mem[AW'(count)] <= wr_char;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            pos      <= '0;
            tick     <= '0;
            char_out <= '0;
            display  <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            pos      <= pos_nxt;
            tick     <= tick_nxt;
            busy     <= (state_nxt == SCROLL);
            done     <= done_nxt;
            char_out <= (state_nxt == SCROLL) ? win_char : '0;
            display  <= (state_nxt == SCROLL) ? win_disp : '1;
        end
    end

endmodule

// File: tb/tb_hex_msg_scroller.sv
// Scoreboard bench for hex_msg_scroller: expected windows are queued when a
// pass is started and popped at every scroll step.
module tb_hex_msg_scroller;

    localparam int DEPTH = 16;
    localparam int NDIG  = 4;
    localparam int TD    = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wr_en = 1'b0, clr = 1'b0, start = 1'b0, loop = 1'b0;
    logic [4:0]  wr_char = '0;
    logic [5*NDIG-1:0] char_out;
    logic [NDIG-1:0]   display;
    logic        busy, done, full;
    logic [4:0]  count;

    hex_msg_scroller #(.DEPTH(DEPTH), .NDIG(NDIG), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_char(wr_char),
        .clr(clr), .start(start), .loop(loop), .char_out(char_out),
        .display(display), .busy(busy), .done(done), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5*NDIG-1:0] ch;
        logic [NDIG-1:0]   disp;
        logic              busy;
        logic              done;
    } exp_t;

    exp_t       sb[$];
    int         errs = 0, checks = 0;
    logic [4:0] mbuf [DEPTH];
    int         mcount = 0;
    logic       seen;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t win(input int p, input logic b, input logic d);
        exp_t e;
        e.ch = '0; e.disp = '1; e.busy = b; e.done = d;
        for (int k = 0; k < NDIG; k++) begin
            int i;
            i = p + NDIG - 1 - k;
            if (i >= NDIG && i < NDIG + mcount) begin
                e.ch[5*k +: 5] = mbuf[i - NDIG];
                e.disp[k] = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic wr(input logic [4:0] c);
        @(negedge clk); wr_en = 1'b1; wr_char = c;
        @(negedge clk); wr_en = 1'b0;
        if (mcount < DEPTH) begin
            mbuf[mcount] = c;
            mcount++;
        end
    endtask

    task automatic do_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        mcount = 0;
    endtask

    task automatic run_pass(input logic lp, input int npass);
        int len;
        len = mcount + NDIG;
        @(negedge clk); start = 1'b1; loop = lp;
        @(negedge clk); start = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
        for (int ps = 0; ps < npass; ps++) begin
            logic last;
            last = (ps == npass - 1) && !lp;
            for (int p = 1; p <= len; p++)
                sb.push_back(win(p, !((p == len) && last), p == len));
            for (int c = 1; c <= len * TD; c++) begin
                @(negedge clk);
                if (c % TD == 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("win_char", 32'(char_out), 32'(e.ch));
                    chk("win_disp", 32'(display), 32'(e.disp));
                    chk("win_busy", 32'(busy), 32'(e.busy));
                    chk("win_done", 32'(done), 32'(e.done));
                end
            end
        end
        loop = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_char", 32'(char_out), 32'd0);
        chk("rst_disp", 32'(display), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        rst_n = 1'b1;

        // basic three-character pass
        wr(5'd1); wr(5'd2); wr(5'd3);
        chk("count3", 32'(count), 32'd3);
        run_pass(1'b0, 1);
        chk("idle_disp", 32'(display), 32'hF);
        chk("idle_char", 32'(char_out), 32'd0);

        // start on empty buffer is ignored
        do_clr();
        chk("clr_count", 32'(count), 32'd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (busy) seen = 1'b1; end
        chk("empty_start_busy", 32'(seen), 32'd0);

        // looping single character, then abort
        wr(5'd5);
        run_pass(1'b1, 2);
        chk("loop_busy", 32'(busy), 32'd1);
        do_clr();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        seen = 1'b0;
        repeat (30) begin @(negedge clk); if (done) seen = 1'b1; end
        chk("abort_no_done", 32'(seen), 32'd0);

        // same-cycle priority
        wr(5'd7); wr(5'd8);
        @(negedge clk); start = 1'b1; clr = 1'b1;
        @(negedge clk); start = 1'b0; clr = 1'b0;
        mcount = 0;
        chk("clr_start_busy", 32'(busy), 32'd0);
        chk("clr_start_count", 32'(count), 32'd0);
        wr(5'd9); wr(5'd10);
        @(negedge clk); start = 1'b1; wr_en = 1'b1; wr_char = 5'd11;
        @(negedge clk); start = 1'b0; wr_en = 1'b0;
        chk("start_wr_count", 32'(count), 32'd2);
        chk("start_wr_busy", 32'(busy), 32'd1);
        do_clr();
        chk("start_wr_abort", 32'(busy), 32'd0);

        // fill to saturation, then scroll the full buffer
        for (int i = 0; i < 17; i++) begin
            logic [4:0] code;
            code = 5'(i * 3 + 1);
            wr(code);
            if (i == 14) chk("full_15", 32'(full), 32'd0);
            if (i >= 15) begin
                chk("full_cnt", 32'(count), 32'd16);
                chk("full_flag", 32'(full), 32'd1);
            end
        end
        run_pass(1'b0, 1);
        chk("full_after_pass", 32'(count), 32'd16);

        // asynchronous reset mid-pass
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_char", 32'(char_out), 32'd0);
        chk("arst_disp", 32'(display), 32'hF);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (done) seen = 1'b1; end
        rst_n = 1'b1;
        mcount = 0;
        repeat (30) begin @(negedge clk); if (done || busy) seen = 1'b1; end
        chk("arst_no_done", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/hex_msg_scroller.md
HEX_MSG_SCROLLER -- requirements
Module: hex_msg_scroller

Interface
REQ-001 Parameter: DEPTH, 16, character buffer entries.
REQ-002 Parameter: NDIG, 4, number of 7-segment digits driven.
REQ-003 Parameter: TICK_DIV, 25_000_000, clk cycles per scroll step (0.5 s at 50 MHz).
REQ-004 Port: clk  in  1  single system clock; all state on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: wr_en  in  1  append wr_char to buffer.
REQ-007 Port: wr_char  in  5  character code (same 5-bit code space as the digit decoder).
REQ-008 Port: clr  in  1  empty buffer / abort scroll.
REQ-009 Port: start  in  1  begin scrolling buffer contents.
REQ-010 Port: loop  in  1  1 = repeat passes until clr; sampled at end of each pass.
REQ-011 Port: char_out  out  5*NDIG  per-digit code; [4:0] = digit 0 (rightmost).
REQ-012 Port: display  out  NDIG  per-digit blank control; 1 = blank, 0 = show (decoder polarity).
REQ-013 Port: busy  out  1  high in SCROLL state.
REQ-014 Port: done  out  1  one-cycle pulse at end of each pass.
REQ-015 Port: count  out  5  number of valid buffer entries, 0..DEPTH.
REQ-016 Port: full  out  1  count == DEPTH.

Function
REQ-017 States: IDLE, SCROLL; all outputs registered.
REQ-018 IDLE write: wr_en && !full && !start && !clr -> buf[count] <= wr_char, count+1; writes when full or in SCROLL are dropped, count unchanged.
REQ-019 IDLE clr -> count <= 0 next cycle; buffer contents need not be cleared.
REQ-020 IDLE start with count > 0 -> SCROLL, pos <= 0, tick counter <= 0; start with count == 0 ignored.
REQ-021 Same-cycle priority: clr > start > wr_en; lower-priority request dropped.
REQ-022 Tick counter runs 0..TICK_DIV-1 only in SCROLL; step occurs when counter == TICK_DIV-1, counter wraps to 0.
REQ-023 Virtual stream: NDIG blanks, buf[0..count-1], NDIG blanks; window at pos shows stream[pos] on digit NDIG-1 .. stream[pos+NDIG-1] on digit 0.
REQ-024 Each step: pos+1; window outputs update on the step cycle's clock edge.
REQ-025 Blank stream slot -> char_out field 5'b00000, display bit 1; buffer slot -> stored code, display bit 0.
REQ-026 Pass ends on the step making pos == count+NDIG: done=1 that cycle; loop=1 -> pos <= 0, stay SCROLL; loop=0 -> IDLE.
REQ-027 Pass length: (count+NDIG)*TICK_DIV cycles from start acceptance to done.
REQ-028 clr in SCROLL -> IDLE and count <= 0 next cycle, no done pulse.
REQ-029 start in SCROLL ignored; buffer contents stable throughout SCROLL.
REQ-030 IDLE outputs: char_out all 0, display all 1, busy 0.
REQ-031 count saturates at DEPTH; full asserted combinationally from count register.

Reset
REQ-032 rst_n low -> immediately: state IDLE, count 0, pos 0, tick counter 0, char_out 0, display all 1, busy 0, done 0, full 0.
REQ-033 Reset mid-SCROLL aborts with no done pulse; buffer contents undefined after reset.
REQ-034 Release of rst_n is synchronised externally; first active edge after release is normal operation.

Verification (TICK_DIV=4, NDIG=4)
REQ-035 Write codes 1,2,3; start, loop=0 -> after 4 cycles char_out[4:0]=1, display=4'b1110; after 8 cycles digits1..0 = 1,2, display=4'b1100; done at cycle 28; IDLE, display=4'b1111.
REQ-036 Write 17 codes -> count=16, full=1 after 16th; 17th dropped, count stays 16.
REQ-037 start with count=0 -> stays IDLE, busy=0 indefinitely.
REQ-038 loop=1, one code -> done every 20 cycles, busy stays 1; clr -> IDLE next cycle, count=0, no further done.
REQ-039 start and clr same cycle with count=2 -> IDLE, count=0, busy=0; wr_en with start -> write dropped, count unchanged.
REQ-040 rst_n low mid-pass -> outputs at reset values within same cycle, no done pulse.
